// File: rtl/button_event_decoder_pkg.sv
// rtl/button_event_decoder_pkg.sv - shared state encoding and timing defaults for the button event decoder
package button_event_decoder_pkg;

    localparam int c_NUM_CH          = 4;
    localparam int c_CNT_WIDTH       = 24;
    localparam int c_LONG_PRESS_DEF  = 12500000;
    localparam int c_DOUBLE_GAP_DEF  = 6250000;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PRESS1 = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4,
        ST_LONG   = 3'd5
    } state_t;

endpackage

// File: rtl/button_event_decoder_if.sv
// rtl/button_event_decoder_if.sv - switch levels in, per-channel event pulses and held levels out
interface button_event_decoder_if;
    import button_event_decoder_pkg::*;

    logic [c_NUM_CH-1:0] i_Switches;
    logic [c_NUM_CH-1:0] o_Click;
    logic [c_NUM_CH-1:0] o_Double;
    logic [c_NUM_CH-1:0] o_Long;
    logic [c_NUM_CH-1:0] o_Held;

    modport master (
        output i_Switches,
        input  o_Click,
        input  o_Double,
        input  o_Long,
        input  o_Held
    );

    modport slave (
        input  i_Switches,
        output o_Click,
        output o_Double,
        output o_Long,
        output o_Held
    );

endinterface

// File: rtl/button_event_decoder_channel.sv
// rtl/button_event_decoder_channel.sv - one switch channel: click/double/long FSM with its own counter
module button_event_channel
    import button_event_decoder_pkg::*;
#(
    parameter int c_LONG_PRESS = c_LONG_PRESS_DEF,
    parameter int c_DOUBLE_GAP = c_DOUBLE_GAP_DEF
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Sw,
    output logic o_Click,
    output logic o_Double,
    output logic o_Long,
    output logic o_Held
);

    // The counter holds the edge count minus one, so expiry is seen one value early
    // and the registered pulse lands exactly after threshold edge N-1.
    localparam logic [c_CNT_WIDTH-1:0] c_LONG_LAST = c_CNT_WIDTH'(c_LONG_PRESS - 2);
    localparam logic [c_CNT_WIDTH-1:0] c_GAP_LAST  = c_CNT_WIDTH'(c_DOUBLE_GAP - 2);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [c_CNT_WIDTH-1:0] w_next_cnt;
    logic                   w_click;
    logic                   w_double;
    logic                   w_long;
    logic                   w_held;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state  <= ST_ARM;
            r_cnt    <= '0;
            o_Click  <= 1'b0;
            o_Double <= 1'b0;
            o_Long   <= 1'b0;
            o_Held   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            o_Click  <= w_click;
            o_Double <= w_double;
            o_Long   <= w_long;
            o_Held   <= w_held;
        end
    end

    // Input changes are tested before expiry so a level change on the threshold edge wins.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt + 1'b1;
        w_click      = 1'b0;
        w_double     = 1'b0;
        w_long       = 1'b0;
        case (r_state)
            ST_ARM: begin
                w_next_cnt = '0;
                if (!i_Sw) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                w_next_cnt = '0;
                if (i_Sw) w_next_state = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (!i_Sw) begin
                    w_next_state = ST_GAP;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_long       = 1'b1;
                    w_next_state = ST_LONG;
                    w_next_cnt   = '0;
                end
            end
            ST_GAP: begin
                if (i_Sw) begin
                    w_next_state = ST_PRESS2;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_GAP_LAST) begin
                    w_click      = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end
            end
            ST_PRESS2: begin
                if (!i_Sw) begin
                    w_double     = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_long       = 1'b1;
                    w_next_state = ST_LONG;
                    w_next_cnt   = '0;
                end
            end
            ST_LONG: begin
                w_next_cnt = '0;
                if (!i_Sw) w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_ARM;
                w_next_cnt   = '0;
            end
        endcase
        w_held = (w_next_state == ST_LONG);
    end

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - four independent button event channels behind one interface
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int c_LONG_PRESS = c_LONG_PRESS_DEF,
    parameter int c_DOUBLE_GAP = c_DOUBLE_GAP_DEF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    button_event_decoder_if.slave bus
);

    logic [c_NUM_CH-1:0] w_click;
    logic [c_NUM_CH-1:0] w_double;
    logic [c_NUM_CH-1:0] w_long;
    logic [c_NUM_CH-1:0] w_held;

    for (genvar g = 0; g < c_NUM_CH; g++) begin : g_ch
        button_event_channel #(
            .c_LONG_PRESS(c_LONG_PRESS),
            .c_DOUBLE_GAP(c_DOUBLE_GAP)
        ) u_channel (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Sw     (bus.i_Switches[g]),
            .o_Click  (w_click[g]),
            .o_Double (w_double[g]),
            .o_Long   (w_long[g]),
            .o_Held   (w_held[g])
        );
    end

    assign bus.o_Click  = w_click;
    assign bus.o_Double = w_double;
    assign bus.o_Long   = w_long;
    assign bus.o_Held   = w_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - directed and randomized checks of button_event_decoder against a behavioural model
module tb_button_event_decoder;

    localparam int L = 20;
    localparam int D = 10;

    localparam int M_WAIT_RELEASE = 0;
    localparam int M_IDLE         = 1;
    localparam int M_FIRST        = 2;
    localparam int M_GAP          = 3;
    localparam int M_SECOND       = 4;
    localparam int M_HELD         = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    button_event_decoder_if bus();

    button_event_decoder #(
        .c_LONG_PRESS(L),
        .c_DOUBLE_GAP(D)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         mode    [4] = '{default: M_WAIT_RELEASE};
    int         elapsed [4] = '{default: 0};
    logic [3:0] e_click  = '0;
    logic [3:0] e_double = '0;
    logic [3:0] e_long   = '0;
    logic [3:0] e_held   = '0;

    // Reference: each channel remembers which phase of a gesture it is in and how many
    // edges have passed since that phase began; thresholds are edge L-1 / D-1.
    always @(posedge clk or posedge rst) begin : model
        int m;
        int e;
        logic s;
        logic [3:0] lc, ld, ll, lh;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                mode[c]    <= M_WAIT_RELEASE;
                elapsed[c] <= 0;
            end
            e_click <= '0; e_double <= '0; e_long <= '0; e_held <= '0;
        end else begin
            lc = '0; ld = '0; ll = '0; lh = '0;
            for (int c = 0; c < 4; c++) begin
                m = mode[c];
                e = elapsed[c] + 1;
                s = bus.i_Switches[c];
                if (m == M_WAIT_RELEASE) begin
                    if (!s) m = M_IDLE;
                end else if (m == M_IDLE) begin
                    if (s) begin m = M_FIRST; e = 0; end
                end else if (m == M_FIRST || m == M_SECOND) begin
                    if (!s) begin
                        if (m == M_SECOND) ld[c] = 1'b1;
                        m = (m == M_SECOND) ? M_IDLE : M_GAP;
                        e = 0;
                    end else if (e == L - 1) begin
                        ll[c] = 1'b1; m = M_HELD; e = 0;
                    end
                end else if (m == M_GAP) begin
                    if (s) begin m = M_SECOND; e = 0; end
                    else if (e == D - 1) begin lc[c] = 1'b1; m = M_IDLE; e = 0; end
                end else begin
                    if (!s) m = M_IDLE;
                end
                lh[c] = (m == M_HELD);
                mode[c]    <= m;
                elapsed[c] <= e;
            end
            e_click <= lc; e_double <= ld; e_long <= ll; e_held <= lh;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({bus.o_Click, bus.o_Double, bus.o_Long, bus.o_Held} !==
                {e_click, e_double, e_long, e_held}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got c=%b d=%b l=%b h=%b expected c=%b d=%b l=%b h=%b",
                         $time, bus.o_Click, bus.o_Double, bus.o_Long, bus.o_Held,
                         e_click, e_double, e_long, e_held);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input int c, input logic v);
        bus.i_Switches[c] = v;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {bus.o_Click, bus.o_Double, bus.o_Long, bus.o_Held};
    endfunction

    initial begin
        int cd [4];
        bit seen;
        bus.i_Switches = '0;
        step(3);
        chk_en = 1'b1;
        check("reset_outputs", all_outs(), 16'h0);
        #1 rst = 1'b0;
        step(3);

        // single click on channel 0
        set_sw(0, 1'b1); step(5); set_sw(0, 1'b0);
        step(9);  check("click_not_early", bus.o_Click[0], 0);
        step(1);  check("click_at_gap", bus.o_Click[0], 1);
        step(1);  check("click_one_cycle", bus.o_Click[0], 0);
        step(5);

        // double click on channel 1
        set_sw(1, 1'b1); step(5); set_sw(1, 1'b0); step(4);
        set_sw(1, 1'b1); step(5); set_sw(1, 1'b0);
        step(1);  check("double_pulse", bus.o_Double[1], 1);
        step(1);  check("double_one_cycle", bus.o_Double[1], 0);
        step(12);

        // long press on channel 2
        set_sw(2, 1'b1);
        step(19); check("long_not_early", bus.o_Long[2], 0);
        step(1);  check("long_and_held", {bus.o_Long[2], bus.o_Held[2]}, 2'b11);
        step(10); check("held_level", {bus.o_Long[2], bus.o_Held[2]}, 2'b01);
        set_sw(2, 1'b0);
        step(1);  check("held_falls", bus.o_Held[2], 0);
        step(12);

        // release on the long-press threshold edge
        set_sw(0, 1'b1); step(19); set_sw(0, 1'b0);
        step(1);  check("threshold_release_no_long", bus.o_Long[0], 0);
        step(9);  check("threshold_release_click", bus.o_Click[0], 1);
        step(5);

        // second press on the gap expiry edge
        set_sw(1, 1'b1); step(3); set_sw(1, 1'b0); step(9);
        set_sw(1, 1'b1);
        step(1);  check("gap_edge_no_click", bus.o_Click[1], 0);
        step(2);  set_sw(1, 1'b0);
        step(1);  check("gap_edge_double", bus.o_Double[1], 1);
        step(12);

        // switch 3 held through reset release
        #1 rst = 1'b1;
        set_sw(3, 1'b1); step(2);
        #1 rst = 1'b0;
        step(30); check("held_through_reset_quiet", all_outs(), 16'h0);
        set_sw(3, 1'b0); step(3);
        set_sw(3, 1'b1); step(3); set_sw(3, 1'b0);
        step(10); check("click_after_rearm", bus.o_Click[3], 1);
        step(5);

        // reset in the middle of a gap
        set_sw(0, 1'b1); step(3); set_sw(0, 1'b0); step(4);
        #1 rst = 1'b1;
        step(1);  check("reset_in_gap_outputs", all_outs(), 16'h0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (bus.o_Click[0]) seen = 1'b1;
        end
        check("no_click_after_reset", seen, 0);

        // overlapping click on channel 0 and long press on channel 3
        set_sw(3, 1'b1); step(3);
        set_sw(0, 1'b1); step(4); set_sw(0, 1'b0);
        step(10); check("concurrent_click0", {bus.o_Click[0], bus.o_Long[3]}, 2'b10);
        step(3);  check("concurrent_long3", {bus.o_Click[0], bus.o_Long[3]}, 2'b01);
        step(5);  set_sw(3, 1'b0);
        step(12);

        // randomized gestures on all channels
        for (int c = 0; c < 4; c++) cd[c] = $urandom_range(1, 26);
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < 4; c++) begin
                cd[c]--;
                if (cd[c] <= 0) begin
                    bus.i_Switches[c] = ~bus.i_Switches[c];
                    cd[c] = $urandom_range(1, 26);
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                #1 rst = 1'b1;
                step(1);
                #1 rst = 1'b0;
            end
            step(1);
        end
        bus.i_Switches = '0;
        step(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
